alu_pipe: RTL

//   Parametrised, registered ALU: WIDTH-bit operands, 8 ops, full Z/N/C/V flags.

---
 rtl/alu_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Registered ALU with valid/ready handshake and iterative MUL.
// Revision : 1.0
// ============================================================================
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [2:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);
    localparam logic [2:0]    c_OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   out_q;
    logic               z_q, n_q, c_q, v_q, valid_q;
    logic [2*WIDTH-1:0] a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH:0]     sum_d, diff_d;
    logic [WIDTH-1:0]   res_d;
    logic               c_d, v_d;
    logic [2*WIDTH-1:0] prod_d;
    logic               accept_d, start_mul_d, load_d;

    assign out       = out_q;
    assign z         = z_q;
    assign n         = n_q;
    assign c         = c_q;
    assign v         = v_q;
    assign out_valid = valid_q;

    always_comb begin
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_HOLD:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept_d    = in_valid & in_ready;
    assign start_mul_d = accept_d & MUL_EN & (aluop == c_OP_MUL);
    assign load_d      = accept_d & ~start_mul_d;

    always_comb begin
        sum_d  = {1'b0, ain} + {1'b0, bin};
        diff_d = {1'b0, ain} - {1'b0, bin};
        res_d  = '0;
        c_d    = 1'b0;
        v_d    = 1'b0;
        case (aluop)
            3'b000: begin
                res_d = sum_d[WIDTH-1:0];
                c_d   = sum_d[WIDTH];
                v_d   = (ain[WIDTH-1] == bin[WIDTH-1]) && (sum_d[WIDTH-1] != ain[WIDTH-1]);
            end
            3'b001: begin
                res_d = diff_d[WIDTH-1:0];
                c_d   = diff_d[WIDTH];
                v_d   = (ain[WIDTH-1] != bin[WIDTH-1]) && (diff_d[WIDTH-1] != ain[WIDTH-1]);
            end
            3'b010:  res_d = ain & bin;
            3'b011:  res_d = ~bin;
            3'b100:  res_d = ain | bin;
            3'b101:  res_d = ain ^ bin;
            3'b111:  res_d = ain;
            // Opcode 110 only reaches this path when the multiplier is disabled.
            default: res_d = '0;
        endcase
    end

    assign prod_d = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (load_d) begin
            out_q   <= res_d;
            z_q     <= (res_d == '0);
            n_q     <= res_d[WIDTH-1];
            c_q     <= c_d;
            v_q     <= v_d;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
        end else if (start_mul_d) begin
            a_q     <= {{WIDTH{1'b0}}, ain};
            b_q     <= bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            state_q <= S_MUL;
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_q <= prod_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == c_LAST) begin
                        out_q   <= prod_d[WIDTH-1:0];
                        z_q     <= (prod_d[WIDTH-1:0] == '0);
                        n_q     <= prod_d[WIDTH-1];
                        c_q     <= |prod_d[2*WIDTH-1:WIDTH];
                        v_q     <= |prod_d[2*WIDTH-1:WIDTH];
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Reaching here with out_ready high means no new op arrived.
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
